// File: rtl/wb_port_scheduler.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against buffered MDU results.
// Optional: define WB_BUSY_MASK_EN to add the registered mdu_busy_mask output.
module wb_port_scheduler #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_valid,
  input  logic [4:0]             pipe_rd,
  input  logic [1:0]             pipe_sel_dm,
  input  logic [XLEN-1:0]        alu_out,
  input  logic [XLEN-1:0]        data_memory_output,
  input  logic [XLEN-1:0]        pc_next_mem,
  output logic                   stall_wb,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [4:0]             mdu_rd,
  input  logic [XLEN-1:0]        mdu_result,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [$clog2(DEPTH):0] buf_count
`ifdef WB_BUSY_MASK_EN
  ,
  output logic [31:0]            mdu_busy_mask
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);

  // Result buffer storage and control state
  logic [4:0]       ent_rd_q   [DEPTH];
  logic [XLEN-1:0]  ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_live_q, ent_live_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;

  logic             pipe_req;
  logic             buf_empty;
  logic             head_live;
  logic             buf_grant;
  logic             pipe_grant;
  logic             pop;
  logic             accept;
  logic             bypass;
  logic             push;
  logic [XLEN-1:0]  pipe_wdata;

  always_comb begin
    case (pipe_sel_dm)
      2'b01:   pipe_wdata = data_memory_output;
      2'b10:   pipe_wdata = pc_next_mem;
      default: pipe_wdata = alu_out;
    endcase
  end

  assign pipe_req  = pipe_valid && (pipe_rd != 5'd0);
  assign buf_empty = (count_q == '0);
  assign head_live = ent_live_q[rd_ptr_q];
  assign mdu_ready = (count_q < DEPTH_C);
  assign accept    = mdu_valid && mdu_ready;

  // A dead head drains on its own and never competes for the write slot.
  assign buf_grant  = !buf_empty && head_live && ((starve_q == STARVE_MAX_C) || !pipe_req);
  assign pipe_grant = pipe_req && !buf_grant;
  assign pop        = !buf_empty && (buf_grant || !head_live);
  assign bypass     = buf_empty && !pipe_req && accept && (mdu_rd != 5'd0);
  assign push       = accept && (mdu_rd != 5'd0) && !bypass;
  assign stall_wb   = pipe_req && buf_grant;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ent_live_d = ent_live_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);

    // WAW kill first; a same-cycle push below re-marks its slot live.
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_grant && ent_live_q[i] && (ent_rd_q[i] == pipe_rd)) ent_live_d[i] = 1'b0;
    end
    if (pop) begin
      ent_live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + AW'(1);
    end
    if (push) begin
      ent_live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (buf_empty || pop) starve_d = '0;
    else if (pipe_grant && (starve_q != STARVE_MAX_C)) starve_d = starve_q + SW'(1);
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (buf_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ent_rd_q[rd_ptr_q];
      rf_wdata_d = ent_data_q[rd_ptr_q];
    end else if (pipe_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_wdata;
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mdu_rd;
      rf_wdata_d = mdu_result;
    end
  end

  // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_live_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ent_live_q <= ent_live_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // NOTE: entry payloads are not reset; the live bits and count already mark them empty.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= mdu_rd;
      ent_data_q[wr_ptr_q] <= mdu_result;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign buf_count = count_q;

`ifdef WB_BUSY_MASK_EN
  logic [31:0] busy_mask_q, busy_mask_d;
  logic [4:0]  rd_next;

  // Built from next-state contents so the registered mask matches the buffer as it stands.
  always_comb begin
    busy_mask_d = '0;
    rd_next     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_next = (push && (wr_ptr_q == AW'(i))) ? mdu_rd : ent_rd_q[i];
      if (ent_live_d[i]) busy_mask_d[rd_next] = 1'b1;
    end
    busy_mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_mask_q <= '0;
    else     busy_mask_q <= busy_mask_d;
  end

  assign mdu_busy_mask = busy_mask_q;
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler (DEPTH=2, STARVE_MAX=4, default build).
module tb_wb_port_scheduler;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [1:0]      pipe_sel_dm;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] data_memory_output;
  logic [XLEN-1:0] pc_next_mem;
  logic            stall_wb;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_result;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [1:0]      buf_count;

  int checks = 0;
  int errors = 0;

  wb_port_scheduler #(.XLEN(XLEN), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .pipe_valid         (pipe_valid),
    .pipe_rd            (pipe_rd),
    .pipe_sel_dm        (pipe_sel_dm),
    .alu_out            (alu_out),
    .data_memory_output (data_memory_output),
    .pc_next_mem        (pc_next_mem),
    .stall_wb           (stall_wb),
    .mdu_valid          (mdu_valid),
    .mdu_ready          (mdu_ready),
    .mdu_rd             (mdu_rd),
    .mdu_result         (mdu_result),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .buf_count          (buf_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [XLEN-1:0] alu);
    pipe_valid  = v;
    pipe_rd     = rd;
    pipe_sel_dm = sel;
    alu_out     = alu;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] res);
    mdu_valid  = v;
    mdu_rd     = rd;
    mdu_result = res;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_pipe(0, 0, 0, 0);
    drive_mdu(0, 0, 0);
    data_memory_output = 32'h0;
    pc_next_mem        = 32'h0;
    tick();
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== 40'h0) begin
      errors++;
      $display("FAIL reset_regs: we/addr/data/count got %b/%0d/%h/%0d expected 0/0/0/0",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
    checks++;
    if ({mdu_ready, stall_wb} !== 2'b10) begin
      errors++;
      $display("FAIL reset_comb: ready/stall got %b/%b expected 1/0", mdu_ready, stall_wb);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_we: got %b expected 0", rf_we);
    end
  endtask

  task automatic test_pipe_sources();
    pc_next_mem        = 32'h104;
    data_memory_output = 32'hAA;
    drive_pipe(1, 5, 2'b10, 32'h77);
    checks++;
    if (stall_wb !== 1'b0) begin
      errors++;
      $display("FAIL pc_stall: got %b expected 0", stall_wb);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h104}) begin
      errors++;
      $display("FAIL pc_write: got %b/%0d/%h expected 1/5/104", rf_we, rf_waddr, rf_wdata);
    end
    drive_pipe(0, 0, 0, 0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h104}) begin
      errors++;
      $display("FAIL hold_idle: got %b/%0d/%h expected 0/5/104", rf_we, rf_waddr, rf_wdata);
    end
    drive_pipe(1, 3, 2'b11, 32'h55);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h55}) begin
      errors++;
      $display("FAIL sel11: got %b/%0d/%h expected 1/3/55", rf_we, rf_waddr, rf_wdata);
    end
    drive_pipe(1, 4, 2'b01, 32'h55);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hAA}) begin
      errors++;
      $display("FAIL sel01: got %b/%0d/%h expected 1/4/aa", rf_we, rf_waddr, rf_wdata);
    end
    drive_pipe(1, 0, 2'b00, 32'h66);
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL rd0_pipe: we got %b expected 0", rf_we);
    end
    drive_pipe(0, 0, 0, 0);
  endtask

  task automatic test_bypass();
    drive_mdu(1, 7, 32'hDEAD);
    checks++;
    if (mdu_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_ready: got %b expected 1", mdu_ready);
    end
    tick();
    drive_mdu(0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd7, 32'hDEAD, 2'd0}) begin
      errors++;
      $display("FAIL bypass_write: got %b/%0d/%h/%0d expected 1/7/dead/0",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
  endtask

  task automatic test_mdu_rd0();
    drive_mdu(1, 0, 32'h1234);
    tick();
    checks++;
    if ({rf_we, buf_count} !== 3'b000) begin
      errors++;
      $display("FAIL mdu_rd0_idle: we/count got %b/%0d expected 0/0", rf_we, buf_count);
    end
    drive_pipe(1, 2, 2'b00, 32'h22);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd2, 32'h22, 2'd0}) begin
      errors++;
      $display("FAIL mdu_rd0_busy: got %b/%0d/%h/%0d expected 1/2/22/0",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
    drive_pipe(0, 0, 0, 0);
    drive_mdu(0, 0, 0);
  endtask

  task automatic test_starvation();
    drive_pipe(1, 1, 2'b00, 32'h101);
    drive_mdu(1, 10, 32'hA0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd1, 32'h101, 2'd1}) begin
      errors++;
      $display("FAIL starve_c0: got %b/%0d/%h/%0d expected 1/1/101/1",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
    drive_pipe(1, 2, 2'b00, 32'h102);
    drive_mdu(1, 11, 32'hB0);
    tick();
    drive_mdu(0, 0, 0);
    checks++;
    if ({mdu_ready, buf_count} !== {1'b0, 2'd2}) begin
      errors++;
      $display("FAIL full_ready: ready/count got %b/%0d expected 0/2", mdu_ready, buf_count);
    end
    for (int rd = 3; rd <= 5; rd++) begin
      drive_pipe(1, 5'(rd), 2'b00, 32'h100 + 32'(rd));
      checks++;
      if (stall_wb !== 1'b0) begin
        errors++;
        $display("FAIL starve_stall_rd%0d: got %b expected 0", rd, stall_wb);
      end
      tick();
      checks++;
      if ({rf_we, rf_waddr} !== {1'b1, 5'(rd)}) begin
        errors++;
        $display("FAIL starve_pipe_rd%0d: we/addr got %b/%0d expected 1/%0d", rd, rf_we, rf_waddr, rd);
      end
    end
    drive_pipe(1, 6, 2'b00, 32'h106);
    checks++;
    if (stall_wb !== 1'b1) begin
      errors++;
      $display("FAIL forced_stall: got %b expected 1", stall_wb);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd10, 32'hA0, 2'd1}) begin
      errors++;
      $display("FAIL forced_pop: got %b/%0d/%h/%0d expected 1/10/a0/1",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
    checks++;
    if (stall_wb !== 1'b0) begin
      errors++;
      $display("FAIL starve_cleared: stall got %b expected 0", stall_wb);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h106}) begin
      errors++;
      $display("FAIL represent: got %b/%0d/%h expected 1/6/106", rf_we, rf_waddr, rf_wdata);
    end
    drive_pipe(0, 0, 0, 0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd11, 32'hB0, 2'd0}) begin
      errors++;
      $display("FAIL drain_idle: got %b/%0d/%h/%0d expected 1/11/b0/0",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
  endtask

  task automatic test_waw_kill();
    drive_pipe(1, 1, 2'b00, 32'h1);
    drive_mdu(1, 9, 32'h99);
    tick();
    drive_mdu(0, 0, 0);
    drive_pipe(1, 9, 2'b00, 32'h11);
    checks++;
    if (stall_wb !== 1'b0) begin
      errors++;
      $display("FAIL kill_stall: got %b expected 0", stall_wb);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd9, 32'h11, 2'd1}) begin
      errors++;
      $display("FAIL kill_write: got %b/%0d/%h/%0d expected 1/9/11/1",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
    drive_pipe(0, 0, 0, 0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b0, 5'd9, 32'h11, 2'd0}) begin
      errors++;
      $display("FAIL dead_pop: got %b/%0d/%h/%0d expected 0/9/11/0",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
  endtask

  task automatic test_kill_same_cycle();
    drive_pipe(1, 1, 2'b00, 32'h1);
    drive_mdu(1, 9, 32'h99);
    tick();
    drive_pipe(1, 9, 2'b00, 32'h11);
    drive_mdu(1, 9, 32'h77);
    tick();
    drive_mdu(0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, buf_count} !== {1'b1, 5'd9, 2'd2}) begin
      errors++;
      $display("FAIL kill_push: we/addr/count got %b/%0d/%0d expected 1/9/2", rf_we, rf_waddr, buf_count);
    end
    drive_pipe(1, 13, 2'b00, 32'h13);
    checks++;
    if (stall_wb !== 1'b0) begin
      errors++;
      $display("FAIL dead_head_stall: got %b expected 0", stall_wb);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd13, 32'h13, 2'd1}) begin
      errors++;
      $display("FAIL dead_pop_pipe: got %b/%0d/%h/%0d expected 1/13/13/1",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
    drive_pipe(0, 0, 0, 0);
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd9, 32'h77, 2'd0}) begin
      errors++;
      $display("FAIL survivor: got %b/%0d/%h/%0d expected 1/9/77/0",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
  endtask

  task automatic test_full_simultaneous();
    drive_pipe(1, 1, 2'b00, 32'h1);
    drive_mdu(1, 20, 32'hC0);
    tick();
    drive_pipe(1, 2, 2'b00, 32'h2);
    drive_mdu(1, 21, 32'hC1);
    tick();
    drive_pipe(0, 0, 0, 0);
    drive_mdu(1, 22, 32'hC2);
    checks++;
    if (mdu_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_ready: got %b expected 0", mdu_ready);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd20, 32'hC0, 2'd1}) begin
      errors++;
      $display("FAIL full_pop: got %b/%0d/%h/%0d expected 1/20/c0/1",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
    checks++;
    if (mdu_ready !== 1'b1) begin
      errors++;
      $display("FAIL retry_ready: got %b expected 1", mdu_ready);
    end
    tick();
    drive_mdu(0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd21, 32'hC1, 2'd1}) begin
      errors++;
      $display("FAIL pop_push: got %b/%0d/%h/%0d expected 1/21/c1/1",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd22, 32'hC2, 2'd0}) begin
      errors++;
      $display("FAIL held_result: got %b/%0d/%h/%0d expected 1/22/c2/0",
               rf_we, rf_waddr, rf_wdata, buf_count);
    end
  endtask

  task automatic test_reset_midop();
    drive_pipe(1, 1, 2'b00, 32'h1);
    drive_mdu(1, 24, 32'hE0);
    tick();
    drive_pipe(1, 2, 2'b00, 32'h2);
    drive_mdu(1, 25, 32'hE1);
    tick();
    drive_pipe(0, 0, 0, 0);
    drive_mdu(0, 0, 0);
    checks++;
    if (buf_count !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d expected 2", buf_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({rf_we, buf_count} !== 3'b000) begin
      errors++;
      $display("FAIL midop_reset: we/count got %b/%0d expected 0/0", rf_we, buf_count);
    end
    tick();
    checks++;
    if ({rf_we, buf_count} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_drain: we/count got %b/%0d expected 0/0", rf_we, buf_count);
    end
  endtask

  initial begin
    test_reset();
    test_pipe_sources();
    test_bypass();
    test_mdu_rd0();
    test_starvation();
    test_waw_kill();
    test_kill_same_cycle();
    test_full_simultaneous();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
